// File: rtl/master_change_ctrl.sv
// master_change_ctrl: sequencer for the master-PIN change procedure.
// Authenticates against the current master, collects a new PIN twice,
// commits it to update_master for one cycle and reports the outcome.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   change_req        one-cycle request to start a change (IDLE only)
//   pin_in            keypad entry, status=1 marks a completed PIN
//   master_pin        stored master, status=0 means none configured
//   upd_ack           new_master_pin.status from update_master
//   upd_enable/pin    drive update_master.enable / pin_in
//   busy              high outside IDLE
//   done / fail       one-cycle outcome pulses
//   fail_code         1 auth, 2 confirm, 3 timeout, 4 rejected, 5 locked
//   tries_left        remaining authentication attempts
//   locked            high during lockout
//
// Optional build macro: MASTER_CHANGE_LOCKOUT_EN enables the LOCKOUT
// state after MAX_TRIES consecutive authentication failures.

package master_change_pkg;
    typedef struct packed {
        logic       status;
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } pinPac_t;
endpackage

module master_change_ctrl
    import master_change_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCK_CYCLES    = 60000,
    localparam int unsigned TW = $clog2(MAX_TRIES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          change_req,
    input  pinPac_t       pin_in,
    input  pinPac_t       master_pin,
    input  logic          upd_ack,
    output logic          upd_enable,
    output pinPac_t       upd_pin,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [2:0]    fail_code,
    output logic [TW-1:0] tries_left,
    output logic          locked
);

    // One counter serves both the entry timeout and the lockout period.
    localparam int unsigned CMAX =
        (TIMEOUT_CYCLES > LOCK_CYCLES) ? TIMEOUT_CYCLES : LOCK_CYCLES;
    localparam int unsigned CW = $clog2(CMAX + 1);

    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);

    localparam pinPac_t PIN_IDLE = '{
        status: 1'b0,
        d3:     4'hF,
        d2:     4'hF,
        d1:     4'hF,
        d0:     4'hF
    };

    localparam logic [2:0] FC_AUTH    = 3'd1;
    localparam logic [2:0] FC_CONFIRM = 3'd2;
    localparam logic [2:0] FC_TIMEOUT = 3'd3;
    localparam logic [2:0] FC_REJECT  = 3'd4;
`ifdef MASTER_CHANGE_LOCKOUT_EN
    localparam logic [2:0] FC_LOCKED  = 3'd5;
    localparam logic [CW-1:0] LK_LAST = CW'(LOCK_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_AUTH,
        S_NEW1,
        S_NEW2,
        S_COMMIT,
        S_CHECK,
        S_LOCKOUT
    } state_t;

    function automatic logic [15:0] digits(input pinPac_t p);
        return {p.d3, p.d2, p.d1, p.d0};
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   buf_q, buf_d;
    logic [TW-1:0] tries_q, tries_d;
    logic [2:0]    code_q, code_d;
    logic          done_d, fail_d;
    logic          done_q, fail_q;
    logic          en_q, busy_q;
    pinPac_t       upd_pin_q;

    logic          entry;
    logic          expired;

    assign entry   = pin_in.status;
    assign expired = (cnt_q == TO_LAST);

    // Next-state logic. cnt_d defaults to zero so that every state
    // change and every accepted entry restarts the counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        buf_d   = buf_q;
        tries_d = tries_q;
        code_d  = code_q;
        done_d  = 1'b0;
        fail_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (change_req) begin
                    state_d = master_pin.status ? S_AUTH : S_NEW1;
                end
            end

            S_AUTH: begin
                if (entry) begin
                    if (digits(pin_in) == digits(master_pin)) begin
                        state_d = S_NEW1;
                        tries_d = TRIES_MAX;
                    end else begin
                        fail_d  = 1'b1;
                        code_d  = FC_AUTH;
                        state_d = S_IDLE;
                        if (tries_q != '0) begin
                            tries_d = tries_q - TW'(1);
                        end
`ifdef MASTER_CHANGE_LOCKOUT_EN
                        if (tries_q <= TW'(1)) begin
                            state_d = S_LOCKOUT;
                        end
`endif
                    end
                end else if (expired) begin
                    fail_d  = 1'b1;
                    code_d  = FC_TIMEOUT;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_NEW1: begin
                if (entry) begin
                    buf_d   = digits(pin_in);
                    state_d = S_NEW2;
                end else if (expired) begin
                    fail_d  = 1'b1;
                    code_d  = FC_TIMEOUT;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_NEW2: begin
                if (entry) begin
                    if (digits(pin_in) == buf_q) begin
                        state_d = S_COMMIT;
                    end else begin
                        fail_d  = 1'b1;
                        code_d  = FC_CONFIRM;
                        state_d = S_IDLE;
                        buf_d   = 16'hFFFF;
                    end
                end else if (expired) begin
                    fail_d  = 1'b1;
                    code_d  = FC_TIMEOUT;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_COMMIT: begin
                state_d = S_CHECK;
            end

            // update_master captured on the COMMIT->CHECK edge; its
            // status tells whether it accepted the digits.
            S_CHECK: begin
                state_d = S_IDLE;
                if (upd_ack) begin
                    done_d = 1'b1;
                end else begin
                    fail_d = 1'b1;
                    code_d = FC_REJECT;
                end
            end

            S_LOCKOUT: begin
`ifdef MASTER_CHANGE_LOCKOUT_EN
                if (change_req) begin
                    fail_d = 1'b1;
                    code_d = FC_LOCKED;
                end
                if (cnt_q == LK_LAST) begin
                    state_d = S_IDLE;
                    tries_d = TRIES_MAX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`else
                state_d = S_IDLE;
`endif
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            buf_q     <= 16'hFFFF;
            tries_q   <= TRIES_MAX;
            code_q    <= 3'd0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            upd_pin_q <= PIN_IDLE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            tries_q   <= tries_d;
            code_q    <= code_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
            en_q      <= (state_d == S_COMMIT);
            busy_q    <= (state_d != S_IDLE);
            upd_pin_q <= (state_d == S_COMMIT)
                       ? pinPac_t'({1'b1, buf_d})
                       : PIN_IDLE;
        end
    end

`ifdef MASTER_CHANGE_LOCKOUT_EN
    logic locked_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            locked_q <= 1'b0;
        end else begin
            locked_q <= (state_d == S_LOCKOUT);
        end
    end

    assign locked = locked_q;
`else
    assign locked = 1'b0;
`endif

    assign upd_enable = en_q;
    assign upd_pin    = upd_pin_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign fail_code  = code_q;
    assign tries_left = tries_q;

endmodule

// File: tb/tb_master_change_ctrl.sv
// tb_master_change_ctrl: directed table-driven bench for the
// master-PIN change sequencer, plus timeout and lockout sequences.

module tb_master_change_ctrl;
    import master_change_pkg::*;

    localparam int TO  = 8;
    localparam int MT  = 3;
    localparam int LK  = 20;
    localparam logic [16:0] IDL = 17'h0FFFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       change_req;
    pinPac_t    pin_in;
    pinPac_t    master_pin;
    logic       upd_ack;
    logic       upd_enable;
    pinPac_t    upd_pin;
    logic       busy;
    logic       done;
    logic       fail;
    logic [2:0] fail_code;
    logic [1:0] tries_left;
    logic       locked;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    master_change_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .MAX_TRIES     (MT),
        .LOCK_CYCLES   (LK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .change_req(change_req),
        .pin_in    (pin_in),
        .master_pin(master_pin),
        .upd_ack   (upd_ack),
        .upd_enable(upd_enable),
        .upd_pin   (upd_pin),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_code (fail_code),
        .tries_left(tries_left),
        .locked    (locked)
    );

    typedef struct {
        logic        r, req, pst;
        logic [15:0] pd;
        logic        ms, ack;
        logic        en;
        logic [16:0] up;
        logic        bz, dn, fl;
        logic [2:0]  cd;
        logic [1:0]  tr;
        logic        lk;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t v(
        input logic r, req, pst, input logic [15:0] pd,
        input logic ms, ack, en, input logic [16:0] up,
        input logic bz, dn, fl, input logic [2:0] cd,
        input logic [1:0] tr, input logic lk);
        vec_t x;
        x.r = r; x.req = req; x.pst = pst; x.pd = pd;
        x.ms = ms; x.ack = ack; x.en = en; x.up = up;
        x.bz = bz; x.dn = dn; x.fl = fl; x.cd = cd;
        x.tr = tr; x.lk = lk;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %0h exp %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, req, pst,
                         input logic [15:0] pd,
                         input logic ms, ack);
        rst        = r;
        change_req = req;
        pin_in     = pinPac_t'({pst, pd});
        master_pin = pinPac_t'({ms, 16'h0000});
        upd_ack    = ack;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string nm, input vec_t x);
        chk({nm, ".en"},   32'(upd_enable), 32'(x.en));
        chk({nm, ".pin"},  32'(upd_pin),    32'(x.up));
        chk({nm, ".busy"}, 32'(busy),       32'(x.bz));
        chk({nm, ".done"}, 32'(done),       32'(x.dn));
        chk({nm, ".fail"}, 32'(fail),       32'(x.fl));
        chk({nm, ".code"}, 32'(fail_code),  32'(x.cd));
        chk({nm, ".tries"},32'(tries_left), 32'(x.tr));
        chk({nm, ".lock"}, 32'(locked),     32'(x.lk));
    endtask

    initial begin
        // r req pst pd ms ack | en up bz dn fl cd tr lk
        tbl[0]  = v(0,0,0,16'h0000,0,0, 0,IDL,      0,0,0,0,3,0);
        tbl[1]  = v(1,1,0,16'h0000,0,0, 0,IDL,      1,0,0,0,3,0);
        tbl[2]  = v(1,0,1,16'h1234,0,0, 0,IDL,      1,0,0,0,3,0);
        tbl[3]  = v(1,0,1,16'h1234,0,0, 1,17'h11234,1,0,0,0,3,0);
        tbl[4]  = v(1,0,0,16'h0000,0,1, 0,IDL,      1,0,0,0,3,0);
        tbl[5]  = v(1,0,0,16'h0000,0,1, 0,IDL,      0,1,0,0,3,0);
        tbl[6]  = v(1,0,0,16'h0000,0,0, 0,IDL,      0,0,0,0,3,0);
        tbl[7]  = v(1,1,1,16'h0000,1,0, 0,IDL,      1,0,0,0,3,0);
        tbl[8]  = v(1,0,1,16'h0000,1,0, 0,IDL,      1,0,0,0,3,0);
        tbl[9]  = v(1,1,1,16'h5678,1,0, 0,IDL,      1,0,0,0,3,0);
        tbl[10] = v(1,0,1,16'h5678,1,0, 1,17'h15678,1,0,0,0,3,0);
        tbl[11] = v(1,0,0,16'h0000,1,1, 0,IDL,      1,0,0,0,3,0);
        tbl[12] = v(1,0,0,16'h0000,1,1, 0,IDL,      0,1,0,0,3,0);
        tbl[13] = v(1,1,0,16'h0000,0,0, 0,IDL,      1,0,0,0,3,0);
        tbl[14] = v(1,0,1,16'h1111,0,0, 0,IDL,      1,0,0,0,3,0);
        tbl[15] = v(1,0,1,16'h1112,0,0, 0,IDL,      0,0,1,2,3,0);
        tbl[16] = v(1,0,0,16'h0000,0,0, 0,IDL,      0,0,0,2,3,0);
        tbl[17] = v(1,1,0,16'h0000,1,0, 0,IDL,      1,0,0,2,3,0);
        tbl[18] = v(1,0,1,16'h9999,1,0, 0,IDL,      0,0,1,1,2,0);
        tbl[19] = v(1,1,0,16'h0000,1,0, 0,IDL,      1,0,0,1,2,0);
        tbl[20] = v(1,0,1,16'h0000,1,0, 0,IDL,      1,0,0,1,3,0);
        tbl[21] = v(1,0,1,16'hA123,1,0, 0,IDL,      1,0,0,1,3,0);
        tbl[22] = v(1,0,1,16'hA123,1,0, 1,17'h1A123,1,0,0,1,3,0);
        tbl[23] = v(1,0,0,16'h0000,1,0, 0,IDL,      1,0,0,1,3,0);
        tbl[24] = v(1,0,0,16'h0000,1,0, 0,IDL,      0,0,1,4,3,0);
        tbl[25] = v(1,1,0,16'h0000,0,0, 0,IDL,      1,0,0,4,3,0);
        tbl[26] = v(1,0,1,16'h1234,0,0, 0,IDL,      1,0,0,4,3,0);
        tbl[27] = v(1,0,1,16'h1234,0,0, 1,17'h11234,1,0,0,4,3,0);
        tbl[28] = v(0,0,0,16'h0000,0,0, 0,IDL,      0,0,0,0,3,0);
        tbl[29] = v(1,0,0,16'h0000,0,0, 0,IDL,      0,0,0,0,3,0);

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].r, tbl[i].req, tbl[i].pst, tbl[i].pd,
                  tbl[i].ms, tbl[i].ack);
            step();
            expect_all($sformatf("row%0d", i), tbl[i]);
        end

        // Timeout in NEW1 with no entry.
        drive(1,1,0,16'h0,0,0); step();
        chk("toA.enter", 32'(busy), 1);
        for (int i = 1; i < TO; i++) begin
            drive(1,0,0,16'h0,0,0); step();
            chk("toA.wait", 32'({busy, fail}), 32'b10);
        end
        drive(1,0,0,16'h0,0,0); step();
        chk("toA.fail", 32'(fail), 1);
        chk("toA.code", 32'(fail_code), 3);
        chk("toA.busy", 32'(busy), 0);

        // Entry on the expiry cycle is accepted instead.
        drive(1,1,0,16'h0,0,0); step();
        for (int i = 1; i < TO; i++) begin
            drive(1,0,0,16'h0,0,0); step();
        end
        drive(1,0,1,16'h4321,0,0); step();
        chk("toB.fail", 32'(fail), 0);
        chk("toB.busy", 32'(busy), 1);
        drive(1,0,1,16'h4321,0,0); step();
        chk("toB.en",  32'(upd_enable), 1);
        chk("toB.pin", 32'(upd_pin), 32'h14321);
        drive(1,0,0,16'h0,0,1); step();
        drive(1,0,0,16'h0,0,1); step();
        chk("toB.done", 32'(done), 1);

        // Timeout in AUTH does not consume a try.
        drive(1,1,0,16'h0,1,0); step();
        for (int i = 1; i < TO; i++) begin
            drive(1,0,0,16'h0,1,0); step();
        end
        drive(1,0,0,16'h0,1,0); step();
        chk("toC.code",  32'(fail_code), 3);
        chk("toC.tries", 32'(tries_left), 3);

        // Three wrong authentications.
        for (int k = 0; k < 3; k++) begin
            drive(1,1,0,16'h0,1,0); step();
            chk("bad.auth", 32'(busy), 1);
            drive(1,0,1,16'h9999,1,0); step();
            chk("bad.fail",  32'(fail), 1);
            chk("bad.code",  32'(fail_code), 1);
            chk("bad.tries", 32'(tries_left), 32'(2 - k));
        end
`ifdef MASTER_CHANGE_LOCKOUT_EN
        chk("lk.locked", 32'(locked), 1);
        chk("lk.busy",   32'(busy), 1);
        drive(1,1,0,16'h0,1,0); step();
        chk("lk.fail", 32'(fail), 1);
        chk("lk.code", 32'(fail_code), 5);
        for (int i = 2; i < LK; i++) begin
            drive(1,0,0,16'h0,1,0); step();
            chk("lk.hold", 32'({locked, fail}), 32'b10);
        end
        drive(1,0,0,16'h0,1,0); step();
        chk("lk.unlock", 32'(locked), 0);
        chk("lk.tries",  32'(tries_left), 3);
        chk("lk.idle",   32'(busy), 0);
`else
        chk("sat.locked", 32'(locked), 0);
        chk("sat.idle",   32'(busy), 0);
        drive(1,1,0,16'h0,1,0); step();
        drive(1,0,1,16'h9999,1,0); step();
        chk("sat.tries", 32'(tries_left), 0);
        chk("sat.fail",  32'(fail), 1);
        drive(1,1,0,16'h0,1,0); step();
        drive(1,0,1,16'h0000,1,0); step();
        chk("sat.reload", 32'(tries_left), 3);
        chk("sat.new1",   32'(busy), 1);
        drive(0,0,0,16'h0,1,0); step();
        chk("sat.rst", 32'(busy), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
